// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: control-bundle field indices and the
// memory map used by the MEM stage (data RAM base and depth, memory-mapped ports).
// Pure constants; no logic.
package mips_pkg;

  // MEM_Ctrl field indices
  localparam int CTRL_MEM_READ       = 0;
  localparam int CTRL_MEM_WRITE      = 1;
  localparam int CTRL_MEM_TO_REG     = 2;
  localparam int CTRL_REG_WRITE      = 3;
  localparam int CTRL_ALU_MEM_OR_PC  = 4;
  localparam int CTRL_BR_EQ          = 5;
  localparam int CTRL_BR_NE          = 6;
  localparam int CTRL_JUMP           = 7;

  // WB_Ctrl field indices: {ALUMemOrPC, MemtoReg, RegWrite}
  localparam int WB_REG_WRITE        = 0;
  localparam int WB_MEM_TO_REG       = 1;
  localparam int WB_ALU_MEM_OR_PC    = 2;

  // Memory map defaults
  localparam int          MIPS_DATA_DEPTH    = 1024;
  localparam logic [31:0] MIPS_DATA_BASE     = 32'h1001_0000;
  localparam logic [31:0] MIPS_PORT_OUT_ADDR = 32'h1001_FFF0;
  localparam logic [31:0] MIPS_PORT_IN_ADDR  = 32'h1001_FFF4;

endpackage

// File: rtl/data_memory_ram.sv
// Data RAM: DEPTH x 32-bit words, synchronous write, asynchronous (combinational) read.
// Latency: write lands on the clock edge with we=1; read data follows addr in the same cycle.
// No backpressure; contents are not reset.
module data_memory_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: data RAM and memory-mapped PortIn/PortOut access,
// branch/jump resolution (PCSrc/PCTarget/Flush combinational), 1-cycle MEM->WB latency.
// No stall/backpressure: the MEM/WB register loads every edge; Flush squashes younger stages.
// Ports: EX/MEM inputs (MEM_*), PortIn switches, PC redirect outputs, PortOut, sticky
// AddrError, and the registered WB_* bundle feeding the writeback muxes.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int          DATA_DEPTH    = MIPS_DATA_DEPTH,
  parameter logic [31:0] DATA_BASE     = MIPS_DATA_BASE,
  parameter logic [31:0] PORT_OUT_ADDR = MIPS_PORT_OUT_ADDR,
  parameter logic [31:0] PORT_IN_ADDR  = MIPS_PORT_IN_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  MEM_Ctrl,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_ReadData2,
  input  logic        MEM_Zero,
  input  logic [31:0] MEM_BranchAddress,
  input  logic [31:0] MEM_JumpAddress,
  input  logic [31:0] MEM_PC_4,
  input  logic [4:0]  MEM_WriteRegister,
  input  logic [7:0]  PortIn,
  output logic        PCSrc,
  output logic [31:0] PCTarget,
  output logic        Flush,
  output logic [31:0] PortOut,
  output logic        AddrError,
  output logic [2:0]  WB_Ctrl,
  output logic [4:0]  WB_WriteRegister,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_ALUResult,
  output logic [31:0] WB_PC_4
);

  localparam int AW = $clog2(DATA_DEPTH);

  logic mem_read, mem_write;
  assign mem_read  = MEM_Ctrl[CTRL_MEM_READ];
  assign mem_write = MEM_Ctrl[CTRL_MEM_WRITE];

  // ---------------- branch / jump resolve ----------------
  logic br_taken;
  always_comb begin
    br_taken = (MEM_Ctrl[CTRL_BR_EQ] & MEM_Zero) | (MEM_Ctrl[CTRL_BR_NE] & ~MEM_Zero);
    PCSrc    = MEM_Ctrl[CTRL_JUMP] | br_taken;
    // Jump outranks a simultaneously taken branch.
    if (MEM_Ctrl[CTRL_JUMP])  PCTarget = {MEM_PC_4[31:28], MEM_JumpAddress[27:0]};
    else if (br_taken)        PCTarget = MEM_BranchAddress;
    else                      PCTarget = MEM_PC_4;
  end
  assign Flush = PCSrc;

  // ---------------- address decode ----------------
  logic [31:0] byte_off, word_idx;
  logic        is_port_out, is_port_in, ram_hit, addr_err;
  always_comb begin
    byte_off    = MEM_ALUResult - DATA_BASE;
    word_idx    = {2'b00, byte_off[31:2]};
    is_port_out = (MEM_ALUResult == PORT_OUT_ADDR);
    is_port_in  = (MEM_ALUResult == PORT_IN_ADDR);
    // Ports decode first so they can never alias a RAM word.
    ram_hit     = !is_port_out && !is_port_in &&
                  (MEM_ALUResult >= DATA_BASE) && (word_idx < 32'(DATA_DEPTH));
    addr_err    = (mem_read | mem_write) &&
                  ((MEM_ALUResult[1:0] != 2'b00) || !(ram_hit || is_port_out || is_port_in));
  end

  // ---------------- data RAM ----------------
  logic        ram_we;
  logic [31:0] ram_rdata;
  // Reset on the same edge suppresses the write.
  assign ram_we = mem_write & ~addr_err & ram_hit & ~reset;

  data_memory_ram #(.DEPTH(DATA_DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (word_idx[AW-1:0]),
    .wdata (MEM_ReadData2),
    .rdata (ram_rdata)
  );

  // ---------------- state ----------------
  logic [7:0]  portin_s1_q, portin_s1_d, portin_s2_q, portin_s2_d;
  logic [31:0] port_out_q, port_out_d;
  logic        addr_error_q, addr_error_d;
  logic [2:0]  wb_ctrl_q, wb_ctrl_d;
  logic [4:0]  wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_pc4_q, wb_pc4_d;

  always_comb begin
    portin_s1_d  = PortIn;
    portin_s2_d  = portin_s1_q;

    port_out_d   = port_out_q;
    if (mem_write && !addr_err && is_port_out) port_out_d = MEM_ReadData2;

    addr_error_d = addr_error_q | addr_err;

    // Load data is zero for non-loads, faulting accesses and the illegal read+write combo.
    wb_rdata_d   = '0;
    if (mem_read && !mem_write && !addr_err) begin
      if (is_port_in)   wb_rdata_d = {24'b0, portin_s2_q};
      else if (ram_hit) wb_rdata_d = ram_rdata;
    end

    wb_ctrl_d    = '0;
    wb_ctrl_d[WB_REG_WRITE]     = MEM_Ctrl[CTRL_REG_WRITE];
    wb_ctrl_d[WB_MEM_TO_REG]    = MEM_Ctrl[CTRL_MEM_TO_REG];
    wb_ctrl_d[WB_ALU_MEM_OR_PC] = MEM_Ctrl[CTRL_ALU_MEM_OR_PC];
    wb_wreg_d    = MEM_WriteRegister;
    wb_alu_d     = MEM_ALUResult;
    wb_pc4_d     = MEM_PC_4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      portin_s1_q  <= '0;
      portin_s2_q  <= '0;
      port_out_q   <= '0;
      addr_error_q <= 1'b0;
      wb_ctrl_q    <= '0;
      wb_wreg_q    <= '0;
      wb_rdata_q   <= '0;
      wb_alu_q     <= '0;
      wb_pc4_q     <= '0;
    end else begin
      portin_s1_q  <= portin_s1_d;
      portin_s2_q  <= portin_s2_d;
      port_out_q   <= port_out_d;
      addr_error_q <= addr_error_d;
      wb_ctrl_q    <= wb_ctrl_d;
      wb_wreg_q    <= wb_wreg_d;
      wb_rdata_q   <= wb_rdata_d;
      wb_alu_q     <= wb_alu_d;
      wb_pc4_q     <= wb_pc4_d;
    end
  end

  assign PortOut          = port_out_q;
  assign AddrError        = addr_error_q;
  assign WB_Ctrl          = wb_ctrl_q;
  assign WB_WriteRegister = wb_wreg_q;
  assign WB_ReadData      = wb_rdata_q;
  assign WB_ALUResult     = wb_alu_q;
  assign WB_PC_4          = wb_pc4_q;

  // Bits with no function here (jump target upper nibble comes from PC+4; byte offset
  // low bits are covered by the alignment check on ALUResult).
  logic unused_bits;
  assign unused_bits = ^{MEM_JumpAddress[31:28], byte_off[1:0]};

endmodule
